// File: rtl/ram_block_writer.sv
// Streams a block of words into a single-port RAM, keeps a running checksum,
// and optionally reads the block back to confirm the stored sum matches.
module ram_block_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [ADDR_WIDTH-1:0] WordCount,
  input  logic                  VerifyEn,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  Enable,
  output logic                  ReadWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] DataIn,
  input  logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [DATA_WIDTH-1:0] Checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_FLUSH, S_VERIFY, S_CHECK, S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  verify_q, verify_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] rb_sum_q, rb_sum_d;
  logic                  error_q, error_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_idx;

  assign last_idx = (idx_q == (count_q - ONE_A));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    verify_d = verify_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    rb_sum_d = rb_sum_q;
    error_d  = error_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d   = BaseAddr;
          count_d  = WordCount;
          verify_d = VerifyEn;
          sum_d    = '0;
          error_d  = 1'b0;
          idx_d    = '0;
          state_d  = (WordCount == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        // The write strobe is registered, so the RAM sees it the cycle after the handshake.
        if (InValid) begin
          wr_en_d = 1'b1;
          addr_d  = base_q + idx_q;
          data_d  = InData;
          sum_d   = sum_q + InData;
          idx_d   = idx_q + ONE_A;
          if (last_idx) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        idx_d    = '0;
        rb_sum_d = '0;
        state_d  = verify_q ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        rb_sum_d = rb_sum_q + DataOut;
        idx_d    = idx_q + ONE_A;
        if (last_idx) state_d = S_CHECK;
      end
      S_CHECK: begin
        error_d = (rb_sum_q != sum_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      verify_q <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      rb_sum_q <= '0;
      error_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      verify_q <= verify_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      rb_sum_q <= rb_sum_d;
      error_q  <= error_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Reads are driven straight from state so DataOut is valid within the same cycle.
  assign InReady   = (state_q == S_WRITE);
  assign Enable    = wr_en_q | (state_q == S_VERIFY);
  assign ReadWrite = ~wr_en_q;
  assign Address   = (state_q == S_VERIFY) ? (base_q + idx_q) : addr_q;
  assign DataIn    = data_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Error     = error_q;
  assign Checksum  = sum_q;

endmodule

// File: tb/tb_ram_block_writer.sv
// Scoreboard bench for ram_block_writer: a driver queues expected RAM accesses
// and results, a negedge monitor pops and compares them as the DUT produces them.
module tb_ram_block_writer;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [15:0] WordCount;
  logic        VerifyEn;
  logic [31:0] InData;
  logic        InValid;
  logic        InReady;
  logic        Enable;
  logic        ReadWrite;
  logic [15:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [31:0] Checksum;

  ram_block_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .BaseAddr(BaseAddr),
    .WordCount(WordCount), .VerifyEn(VerifyEn), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Enable(Enable), .ReadWrite(ReadWrite), .Address(Address),
    .DataIn(DataIn), .DataOut(DataOut), .Busy(Busy), .Done(Done), .Error(Error),
    .Checksum(Checksum)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // RAM model; optionally returns zero at 0x0012 to provoke a verify failure.
  logic [31:0] ram [0:65535];
  bit          corrupt_12 = 1'b0;
  always @(posedge Clock) if (Enable && !ReadWrite) ram[Address] <= DataIn;
  always_comb begin
    DataOut = '0;
    if (Enable && ReadWrite)
      DataOut = (corrupt_12 && Address == 16'h0012) ? 32'h0 : ram[Address];
  end

  typedef struct packed { int cyc; logic [15:0] addr; logic [31:0] data; } acc_t;
  typedef struct packed { int cyc; logic [31:0] sum; logic err; } res_t;
  acc_t exp_wr[$];
  acc_t exp_rd[$];
  res_t exp_done[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] blk_data [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every RAM access and Done pulse must match the head of its queue.
  always @(negedge Clock) begin
    acc_t a;
    res_t r;
    if (Enable && !ReadWrite) begin
      if (exp_wr.size() == 0) fail("unexpected_write", {16'h0, Address});
      else begin
        a = exp_wr.pop_front();
        check("wr_cycle", a.cyc >= 0 ? 64'(cyc) : 64'(0), 64'(a.cyc));
        check("wr_addr", {48'h0, Address}, {48'h0, a.addr});
        check("wr_data", {32'h0, DataIn}, {32'h0, a.data});
      end
    end
    if (Enable && ReadWrite) begin
      if (exp_rd.size() == 0) fail("unexpected_read", {16'h0, Address});
      else begin
        a = exp_rd.pop_front();
        check("rd_cycle", 64'(cyc), 64'(a.cyc));
        check("rd_addr", {48'h0, Address}, {48'h0, a.addr});
      end
    end
    if (Done) begin
      if (exp_done.size() == 0) fail("unexpected_done", 64'(cyc));
      else begin
        r = exp_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(r.cyc));
        check("done_checksum", {32'h0, Checksum}, {32'h0, r.sum});
        check("done_error", {63'h0, Error}, {63'h0, r.err});
        check("done_busy", {63'h0, Busy}, 64'h1);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (Busy && k < limit) begin
      step();
      k++;
    end
    check("idle_after_block", {63'h0, Busy}, 64'h0);
  endtask

  // gap: 0 = InValid held, 1 = toggling 1,0,1,..., 2 = random.
  task automatic run_block(input logic [15:0] base, input int count, input bit verify,
                           input bit corrupt, input int gap, input bit noise);
    int i = 0;
    int k = 0;
    int last_e;
    bit v;
    bit hs;
    logic [31:0] sum = '0;
    logic [31:0] rb = '0;
    logic [15:0] a;
    res_t r;
    corrupt_12 = corrupt;
    Start = 1'b1; BaseAddr = base; WordCount = count[15:0]; VerifyEn = verify;
    step();
    Start = 1'b0;
    check("start_busy", {63'h0, Busy}, 64'h1);
    check("start_checksum_clr", {32'h0, Checksum}, 64'h0);
    check("start_error_clr", {63'h0, Error}, 64'h0);
    last_e = cyc;
    while (i < count && k < count * 4 + 8) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      InValid = v;
      InData  = blk_data[i];
      if (noise) begin
        Start = 1'($urandom_range(0, 1)); BaseAddr = 16'($urandom); WordCount = 16'($urandom);
        VerifyEn = 1'($urandom_range(0, 1));
      end
      hs = v && InReady;
      step();
      if (hs) begin
        a = base + 16'(i);
        exp_wr.push_back('{cyc: cyc, addr: a, data: blk_data[i]});
        sum = sum + blk_data[i];
        rb  = rb + ((corrupt && a == 16'h0012) ? 32'h0 : blk_data[i]);
        i++;
        last_e = cyc;
      end
      k++;
    end
    InValid = 1'b0;
    Start   = 1'b0;
    check("all_handshakes", 64'(i), 64'(count));
    if (verify && count > 0)
      for (int j = 0; j < count; j++)
        exp_rd.push_back('{cyc: last_e + 1 + j, addr: base + 16'(j), data: 32'h0});
    r.sum = sum;
    r.err = verify && count > 0 && (rb != sum);
    r.cyc = (count == 0) ? last_e : (verify ? last_e + count + 2 : last_e + 1);
    exp_done.push_back(r);
    if (noise && count > 0) begin
      Start = 1'b1; BaseAddr = 16'($urandom); WordCount = 16'($urandom);
      step();
      Start = 1'b0;
    end
    wait_idle(count + 20);
    repeat (3) step();
    check("held_checksum", {32'h0, Checksum}, {32'h0, r.sum});
    check("held_error", {63'h0, Error}, {63'h0, r.err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, {63'h0, Enable}, 64'h0);
    check({tag, "_readwrite"}, {63'h0, ReadWrite}, 64'h1);
    check({tag, "_address"}, {48'h0, Address}, 64'h0);
    check({tag, "_datain"}, {32'h0, DataIn}, 64'h0);
    check({tag, "_inready"}, {63'h0, InReady}, 64'h0);
    check({tag, "_busy"}, {63'h0, Busy}, 64'h0);
    check({tag, "_done"}, {63'h0, Done}, 64'h0);
    check({tag, "_error"}, {63'h0, Error}, 64'h0);
    check({tag, "_checksum"}, {32'h0, Checksum}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; Start = 1'b0; BaseAddr = '0; WordCount = '0; VerifyEn = 1'b0;
    InData = '0; InValid = 1'b0;
    repeat (3) step();
    check_reset_outputs("por");
    Resetn = 1'b1;
    step();

    // Directed: plain write of 1..4 at 0x0010.
    for (int i = 0; i < 4; i++) blk_data[i] = 32'(i + 1);
    run_block(16'h0010, 4, 1'b0, 1'b0, 0, 1'b0);
    check("write_checksum_0xA", {32'h0, Checksum}, 64'hA);
    // Same block with readback, then with a faulty RAM word at 0x0012.
    run_block(16'h0010, 4, 1'b1, 1'b0, 0, 1'b0);
    run_block(16'h0010, 4, 1'b1, 1'b1, 0, 1'b0);
    check("verify_fail_error", {63'h0, Error}, 64'h1);
    corrupt_12 = 1'b0;
    // Address wrap with gapped InValid.
    for (int i = 0; i < 3; i++) blk_data[i] = 32'hA500_0000 + 32'(i);
    run_block(16'hFFFE, 3, 1'b1, 1'b0, 1, 1'b0);
    // Empty block.
    run_block(16'h1234, 0, 1'b1, 1'b0, 0, 1'b0);
    check("empty_checksum", {32'h0, Checksum}, 64'h0);
    // Start pulses while busy must be ignored.
    for (int i = 0; i < 6; i++) blk_data[i] = $urandom;
    run_block(16'h0200, 6, 1'b1, 1'b0, 2, 1'b1);

    // Randomised blocks.
    for (int t = 0; t < 12; t++) begin
      int n;
      logic [15:0] b;
      n = $urandom_range(1, 12);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h000C, 16'h0012))
                                      : 16'($urandom);
      for (int i = 0; i < n; i++) blk_data[i] = $urandom;
      run_block(b, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    corrupt_12 = 1'b0;

    // Reset in the middle of a write burst: outputs clear at once, no further access.
    Start = 1'b1; BaseAddr = 16'h0100; WordCount = 16'd8; VerifyEn = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InData = 32'hC0DE_0000 + 32'(i);
      step();
      exp_wr.push_back('{cyc: cyc, addr: 16'h0100 + 16'(i), data: 32'hC0DE_0000 + 32'(i)});
    end
    Resetn = 1'b0;
    exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) step();
    Resetn = 1'b1;
    repeat (6) step();
    check("post_reset_idle", {63'h0, Busy}, 64'h0);
    InValid = 1'b0;
    repeat (2) step();

    check("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
    check("done_queue_empty", 64'(exp_done.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_block_writer.md
RAM_BLOCK_WRITER -- requirements
Module: ram_block_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Start  input  1  begin block transfer; sampled only in IDLE.
REQ-006 SHALL have port BaseAddr  input  ADDR_WIDTH  first RAM address; latched on accepted Start.
REQ-007 SHALL have port WordCount  input  ADDR_WIDTH  number of words; latched on accepted Start.
REQ-008 SHALL have port VerifyEn  input  1  enable readback check; latched on accepted Start.
REQ-009 SHALL have port InData  input  DATA_WIDTH  source word.
REQ-010 SHALL have port InValid  input  1  InData valid.
REQ-011 SHALL have port InReady  output  1  block accepts InData this cycle.
REQ-012 SHALL have port Enable  output  1  RAM enable.
REQ-013 SHALL have port ReadWrite  output  1  RAM direction, 1 = read, 0 = write.
REQ-014 SHALL have port Address  output  ADDR_WIDTH  RAM address.
REQ-015 SHALL have port DataIn  output  DATA_WIDTH  RAM write data.
REQ-016 SHALL have port DataOut  input  DATA_WIDTH  RAM read data, combinationally valid while Enable=1, ReadWrite=1.
REQ-017 SHALL have ports Busy, Done, Error  output  1 each; Checksum  output  DATA_WIDTH.

Function
REQ-018 SHALL implement states IDLE, WRITE, FLUSH, VERIFY, CHECK, DONE; Busy=1 in every state except IDLE.
REQ-019 IDLE: Start=1 -> latch BaseAddr/WordCount/VerifyEn, clear Checksum and Error, index=0; next state WRITE, or DONE if WordCount=0.
REQ-020 Start while not IDLE SHALL be ignored.
REQ-021 WRITE: InReady=1; handshake = InValid & InReady; no handshake -> no RAM access next cycle.
REQ-022 Handshake at edge k SHALL register Enable=1, ReadWrite=0, Address=BaseAddr+index, DataIn=InData for exactly cycle k+1; back-to-back handshakes give one write per cycle.
REQ-023 Each handshake SHALL add InData to Checksum modulo 2^DATA_WIDTH and increment index.
REQ-024 Address SHALL wrap modulo 2^ADDR_WIDTH (0xFFFF+1 -> 0x0000).
REQ-025 Handshake on word WordCount-1 -> FLUSH; FLUSH lasts one cycle (carries last write strobe), InReady=0; then VERIFY if VerifyEn else DONE.
REQ-026 VERIFY: reset index and readback sum on entry; each cycle Enable=1, ReadWrite=1, Address=BaseAddr+index; at cycle-ending edge add DataOut to readback sum and increment index; after WordCount reads -> CHECK.
REQ-027 CHECK: Enable=0; Error=1 if readback sum != Checksum; next DONE.
REQ-028 DONE: Done=1 for exactly one cycle, Enable=0; next IDLE.
REQ-029 Outside write/read cycles Enable=0; ReadWrite=1 when idle; InReady=0 in every state except WRITE.
REQ-030 Error and Checksum SHALL hold their values from DONE until the next accepted Start.

Reset
REQ-031 Resetn=0 SHALL immediately force IDLE, Enable=0, ReadWrite=1, Address=0, DataIn=0, InReady=0, Busy=0, Done=0, Error=0, Checksum=0, index=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no further RAM access; Start is required to resume.

Verification
REQ-033 Reset: drive Resetn=0 mid-WRITE -> all outputs at REQ-031 values in the same cycle, no Enable pulse afterward.
REQ-034 Write: BaseAddr=0x0010, WordCount=4, VerifyEn=0, data 1,2,3,4, InValid held 1 -> writes to 0x0010..0x0013 in 4 consecutive cycles, Done pulse 2 cycles after last handshake, Checksum=0x0000000A, Error=0.
REQ-035 Verify pass: same as REQ-034 with VerifyEn=1 and a correct RAM model -> 4 consecutive reads at 0x0010..0x0013 after FLUSH, Error=0.
REQ-036 Verify fail: RAM model returns 0x00000000 at 0x0012 -> Error=1, held until the next Start.
REQ-037 Wrap and gaps: BaseAddr=0xFFFE, WordCount=3, InValid toggling 1,0,1,0,1 -> writes only after handshakes, at 0xFFFE, 0xFFFF, 0x0000.
REQ-038 Corner: WordCount=0 -> Done one cycle after IDLE exit, no Enable pulse, Checksum=0; Start pulsed while Busy=1 -> ignored.
